alu_writeback: RTL and testbench

ALU_WRITEBACK -- requirements
Module: alu_writeback

---
 rtl/alu_writeback_if.sv | 23 ++
 rtl/alu_writeback.sv | 112 +++++++++++
 tb/tb_alu_writeback.sv | 229 ++++++++++++++++++++++
 3 files changed

// File: rtl/alu_writeback_if.sv
// Result-in / register-write-out handshake bundle for alu_writeback.
// master = upstream ALU and register file side, slave = the writeback block.
interface alu_writeback_if;
    logic        res_valid;
    logic        res_ready;
    logic [63:0] res_data;
    logic [3:0]  res_sel;
    logic [4:0]  res_dest;
    logic        wb_valid;
    logic        wb_ready;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;

    modport master (
        output res_valid, res_data, res_sel, res_dest, wb_ready,
        input  res_ready, wb_valid, wb_addr, wb_data
    );

    modport slave (
        input  res_valid, res_data, res_sel, res_dest, wb_ready,
        output res_ready, wb_valid, wb_addr, wb_data
    );
endinterface

// File: rtl/alu_writeback.sv
// ALU result writeback: HI/LO capture for mul/div, FIFO-buffered register writes otherwise.
// Optional WB_BYPASS_EN: an empty FIFO forwards an accepted result straight to wb_*.
module alu_writeback #(
    parameter int DEPTH = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    alu_writeback_if.slave       bus,
    output logic [31:0]          hi,
    output logic [31:0]          lo,
    output logic [4:0]           count,
    output logic                 illegal_op
);

    localparam int         AW      = $clog2(DEPTH);
    localparam logic [4:0] DEPTH_C = 5'(DEPTH);

    logic [36:0]   mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [4:0]    count_q, count_d;
    logic [31:0]   hi_q, hi_d;
    logic [31:0]   lo_q, lo_d;
    logic          illegal_q, illegal_d;

    logic accept;
    logic is_muldiv;
    logic is_illegal;
    logic push_type;
    logic push;
    logic pop;
    logic fifo_empty;

    assign fifo_empty = (count_q == 5'd0);
    assign is_muldiv  = (bus.res_sel == 4'b0011) || (bus.res_sel == 4'b0100);
    assign is_illegal = (bus.res_sel == 4'b0000) || (bus.res_sel == 4'b1111);
    assign push_type  = !is_muldiv && !is_illegal && (bus.res_dest != 5'd0);
    assign accept     = bus.res_valid && bus.res_ready;

    assign bus.res_ready = (count_q != DEPTH_C);

`ifdef WB_BYPASS_EN
    logic bypass_act;
    // A push-type result seen while empty is presented directly; it only lands
    // in the FIFO if the register file does not take it this cycle.
    assign bypass_act   = fifo_empty && accept && push_type;
    assign bus.wb_valid = !fifo_empty || bypass_act;
    assign bus.wb_addr  = fifo_empty ? bus.res_dest : mem_q[rd_ptr_q][36:32];
    assign bus.wb_data  = fifo_empty ? bus.res_data[31:0] : mem_q[rd_ptr_q][31:0];
    assign pop          = !fifo_empty && bus.wb_ready;
    assign push         = accept && push_type && !(bypass_act && bus.wb_ready);
`else
    assign bus.wb_valid = !fifo_empty;
    assign bus.wb_addr  = mem_q[rd_ptr_q][36:32];
    assign bus.wb_data  = mem_q[rd_ptr_q][31:0];
    assign pop          = bus.wb_valid && bus.wb_ready;
    assign push         = accept && push_type;
`endif

    always_comb begin
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        illegal_d = illegal_q;
        count_d   = count_q + {4'd0, push} - {4'd0, pop};
        if (push) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        if (accept && is_muldiv) begin
            hi_d = bus.res_data[63:32];
            lo_d = bus.res_data[31:0];
        end
        if (accept && is_illegal) begin
            illegal_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
            illegal_q <= 1'b0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            illegal_q <= illegal_d;
        end
    end

    // Storage is not reset: contents are meaningless whenever count is zero.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= {bus.res_dest, bus.res_data[31:0]};
        end
    end

    assign hi         = hi_q;
    assign lo         = lo_q;
    assign count      = count_q;
    assign illegal_op = illegal_q;

endmodule

// File: tb/tb_alu_writeback.sv
// Directed-vector bench for alu_writeback (DEPTH=4); inputs change and outputs
// are observed on the falling edge.
module tb_alu_writeback;

    logic        clk;
    logic        rst_n;
    logic [31:0] hi;
    logic [31:0] lo;
    logic [4:0]  count;
    logic        illegal_op;

    int total;
    int bad;

    alu_writeback_if bus_if ();

    alu_writeback #(.DEPTH(4)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .bus        (bus_if),
        .hi         (hi),
        .lo         (lo),
        .count      (count),
        .illegal_op (illegal_op)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end else begin
            $display("ok   %s: 0x%0h", tag, got);
        end
    endtask

    task automatic drive(input logic v, input logic [3:0] sel, input logic [4:0] dest,
                         input logic [63:0] data);
        bus_if.res_valid = v;
        bus_if.res_sel   = sel;
        bus_if.res_dest  = dest;
        bus_if.res_data  = data;
    endtask

    task automatic idle();
        drive(1'b0, 4'b0001, 5'd0, 64'd0);
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst_n = 1'b0;
        idle();
        bus_if.wb_ready = 1'b0;

        // reset state
        repeat (2) @(negedge clk);
        check("rst_count", 64'(count), 64'd0);
        check("rst_wb_valid", 64'(bus_if.wb_valid), 64'd0);
        check("rst_hi", 64'(hi), 64'd0);
        check("rst_illegal", 64'(illegal_op), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_ready", 64'(bus_if.res_ready), 64'd1);

        // single push then pop
        bus_if.wb_ready = 1'b1;
        drive(1'b1, 4'b0001, 5'd3, 64'h0000_0000_0000_0007);
`ifdef WB_BYPASS_EN
        #1;
        check("byp_wb_valid", 64'(bus_if.wb_valid), 64'd1);
        check("byp_wb_addr", 64'(bus_if.wb_addr), 64'd3);
        check("byp_wb_data", 64'(bus_if.wb_data), 64'd7);
        @(negedge clk);
        idle();
        check("byp_count", 64'(count), 64'd0);
        // dest=9 data=0x55 is consumed in the same cycle
        drive(1'b1, 4'b0010, 5'd9, 64'h55);
        #1;
        check("byp9_wb_valid", 64'(bus_if.wb_valid), 64'd1);
        check("byp9_wb_addr", 64'(bus_if.wb_addr), 64'd9);
        check("byp9_wb_data", 64'(bus_if.wb_data), 64'h55);
        @(negedge clk);
        idle();
        check("byp9_count", 64'(count), 64'd0);
`else
        #1;
        check("lat_no_comb", 64'(bus_if.wb_valid), 64'd0);
        @(negedge clk);
        idle();
        check("lat_wb_valid", 64'(bus_if.wb_valid), 64'd1);
        check("lat_wb_addr", 64'(bus_if.wb_addr), 64'd3);
        check("lat_wb_data", 64'(bus_if.wb_data), 64'd7);
        check("lat_count", 64'(count), 64'd1);
        @(negedge clk);
        check("lat_count_pop", 64'(count), 64'd0);
        check("lat_wb_valid_pop", 64'(bus_if.wb_valid), 64'd0);
`endif

        // fill to full with register file stalled
        bus_if.wb_ready = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            drive(1'b1, 4'b0010, 5'(i), {32'hDEAD_0000, 32'(100 + i)});
            @(negedge clk);
        end
        idle();
        check("full_count", 64'(count), 64'd4);
        check("full_ready", 64'(bus_if.res_ready), 64'd0);
        // offered while full, with a pop in the same cycle: must not be taken
        drive(1'b1, 4'b0010, 5'd7, 64'h77);
        bus_if.wb_ready = 1'b1;
        #1;
        check("full_ready_pop", 64'(bus_if.res_ready), 64'd0);
        check("order_addr1", 64'(bus_if.wb_addr), 64'd1);
        check("order_data1", 64'(bus_if.wb_data), 64'd101);
        @(negedge clk);
        idle();
        check("after_pop_count", 64'(count), 64'd3);
        check("after_pop_ready", 64'(bus_if.res_ready), 64'd1);
        for (int i = 2; i <= 4; i++) begin
            check($sformatf("order_addr%0d", i), 64'(bus_if.wb_addr), 64'(i));
            check($sformatf("order_data%0d", i), 64'(bus_if.wb_data), 64'(100 + i));
            @(negedge clk);
        end
        check("drain_count", 64'(count), 64'd0);
        check("drain_wb_valid", 64'(bus_if.wb_valid), 64'd0);

        // mul result goes to HI/LO only
        drive(1'b1, 4'b0011, 5'd6, 64'h1234_5678_9ABC_DEF0);
        @(negedge clk);
        idle();
        check("mul_hi", 64'(hi), 64'h1234_5678);
        check("mul_lo", 64'(lo), 64'h9ABC_DEF0);
        check("mul_count", 64'(count), 64'd0);

        // dest 0 is discarded silently
        drive(1'b1, 4'b0001, 5'd0, 64'h99);
        @(negedge clk);
        idle();
        check("dest0_count", 64'(count), 64'd0);
        check("dest0_wb_valid", 64'(bus_if.wb_valid), 64'd0);
        check("dest0_illegal", 64'(illegal_op), 64'd0);

        // illegal opcode, then sticky across legal traffic
        drive(1'b1, 4'b1111, 5'd5, 64'h1);
        @(negedge clk);
        idle();
        check("ill_flag", 64'(illegal_op), 64'd1);
        check("ill_count", 64'(count), 64'd0);
        check("ill_wb_valid", 64'(bus_if.wb_valid), 64'd0);
        bus_if.wb_ready = 1'b0;
        drive(1'b1, 4'b0001, 5'd2, 64'h22);
        @(negedge clk);
        idle();
        check("ill_legal_count", 64'(count), 64'd1);
        check("ill_sticky", 64'(illegal_op), 64'd1);
        bus_if.wb_ready = 1'b1;
        @(negedge clk);
        check("ill_drain", 64'(count), 64'd0);

        // div accepted while the head is popped: head advances normally
        bus_if.wb_ready = 1'b0;
        drive(1'b1, 4'b0101, 5'd10, 64'hA);
        @(negedge clk);
        drive(1'b1, 4'b0110, 5'd11, 64'hB);
        @(negedge clk);
        drive(1'b1, 4'b0100, 5'd12, 64'hCAFE_BABE_0BAD_F00D);
        bus_if.wb_ready = 1'b1;
        @(negedge clk);
        idle();
        bus_if.wb_ready = 1'b0;
        check("div_hi", 64'(hi), 64'hCAFE_BABE);
        check("div_lo", 64'(lo), 64'h0BAD_F00D);
        check("div_count", 64'(count), 64'd1);
        check("div_head_addr", 64'(bus_if.wb_addr), 64'd11);
        check("div_head_data", 64'(bus_if.wb_data), 64'hB);
        bus_if.wb_ready = 1'b1;
        @(negedge clk);
        check("div_drain", 64'(count), 64'd0);

        // streaming push+pop across pointer wrap
        for (int k = 0; k < 12; k++) begin
            drive(1'b1, 4'b0111, 5'(k + 1), 64'(32'h200 + k));
`ifdef WB_BYPASS_EN
            #1;
            check($sformatf("stream_data%0d", k), 64'(bus_if.wb_data), 64'(32'h200 + k));
            check($sformatf("stream_count%0d", k), 64'(count), 64'd0);
`else
            if (k > 0) begin
                check($sformatf("stream_count%0d", k), 64'(count), 64'd1);
                check($sformatf("stream_addr%0d", k), 64'(bus_if.wb_addr), 64'(k));
                check($sformatf("stream_data%0d", k), 64'(bus_if.wb_data), 64'(32'h200 + k - 1));
            end
`endif
            @(negedge clk);
        end
        idle();
        @(negedge clk);
        check("stream_end_count", 64'(count), 64'd0);

        // asynchronous reset in the middle of a cycle
        bus_if.wb_ready = 1'b0;
        drive(1'b1, 4'b0001, 5'd4, 64'h44);
        @(negedge clk);
        @(negedge clk);
        idle();
        check("pre_arst_count", 64'(count), 64'd2);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_count", 64'(count), 64'd0);
        check("arst_wb_valid", 64'(bus_if.wb_valid), 64'd0);
        check("arst_hi", 64'(hi), 64'd0);
        check("arst_lo", 64'(lo), 64'd0);
        check("arst_illegal", 64'(illegal_op), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("arst_ready", 64'(bus_if.res_ready), 64'd1);
        check("arst_count_hold", 64'(count), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
